// File: rtl/ula_logic_pipe_if.sv
//==============================================================================
// Module      : ula_logic_pipe_if
// Description : Operand/result handshake bundle for the pipelined logic ULA.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ula_logic_pipe_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic [2:0]           in_op;
   logic                 in_chain;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out;
   logic                 zero_flag;
   logic                 parity;
   logic [CNT_W-1:0]     res_count;

   modport master (
      output in_valid, in_a, in_b, in_op, in_chain, out_ready,
      input  in_ready, out_valid, out, zero_flag, parity, res_count
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, in_chain, out_ready,
      output in_ready, out_valid, out, zero_flag, parity, res_count
   );
endinterface

`default_nettype wire

// File: rtl/ula_logic_pipe.sv
//==============================================================================
// Module      : ula_logic_pipe
// Description : Two-stage valid/ready bitwise-logic ULA with chain mode and
//               saturating delivered-result counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ula_logic_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   ula_logic_pipe_if.slave    bus
);

   localparam logic [2:0] c_op_and  = 3'b000;
   localparam logic [2:0] c_op_or   = 3'b001;
   localparam logic [2:0] c_op_nand = 3'b010;
   localparam logic [2:0] c_op_xor  = 3'b011;
   localparam logic [2:0] c_op_nor  = 3'b100;
   localparam logic [2:0] c_op_nota = 3'b101;
   localparam logic [2:0] c_op_xnor = 3'b110;
   localparam logic [2:0] c_op_pass = 3'b111;

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   // Stage 1: captured beat, chain resolution deferred to the S1->S2 move
   logic               r_s1_valid;
   logic [WIDTH-1:0]   r_s1_a;
   logic [WIDTH-1:0]   r_s1_b;
   logic [2:0]         r_s1_op;
   logic               r_s1_chain;

   // Stage 2: result and flags presented downstream
   logic               r_s2_valid;
   logic [2*WIDTH-1:0] r_out;
   logic               r_zero;
   logic               r_parity;

   logic [WIDTH-1:0]   r_acc;
   logic [CNT_W-1:0]   r_count;

   logic               w_s2_free;
   logic               w_s1_move;
   logic               w_in_ready;
   logic               w_accept;
   logic               w_deliver;
   logic [WIDTH-1:0]   w_a;
   logic [WIDTH-1:0]   w_result;

   assign w_s2_free  = !r_s2_valid || bus.out_ready;
   assign w_s1_move  = r_s1_valid && w_s2_free;
   assign w_in_ready = !r_s1_valid || w_s1_move;
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_deliver  = r_s2_valid && bus.out_ready;

   // acc is read at move time so back-to-back chained beats see the newest result
   assign w_a = r_s1_chain ? r_acc : r_s1_a;

   always_comb begin
      w_result = '0;
      case (r_s1_op)
         c_op_and:  w_result = w_a & r_s1_b;
         c_op_or:   w_result = w_a | r_s1_b;
         c_op_nand: w_result = ~(w_a & r_s1_b);
         c_op_xor:  w_result = w_a ^ r_s1_b;
         c_op_nor:  w_result = ~(w_a | r_s1_b);
         c_op_nota: w_result = ~w_a;
         c_op_xnor: w_result = ~(w_a ^ r_s1_b);
         c_op_pass: w_result = w_a;
         default:   w_result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_op    <= '0;
         r_s1_chain <= 1'b0;
      end else if (w_accept) begin
         r_s1_valid <= 1'b1;
         r_s1_a     <= bus.in_a;
         r_s1_b     <= bus.in_b;
         r_s1_op    <= bus.in_op;
         r_s1_chain <= bus.in_chain;
      end else if (w_s1_move) begin
         r_s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_out      <= '0;
         r_zero     <= 1'b1;
         r_parity   <= 1'b0;
         r_acc      <= '0;
      end else if (w_s1_move) begin
         r_s2_valid <= 1'b1;
         r_out      <= {{WIDTH{1'b0}}, w_result};
         r_zero     <= (w_result == '0);
         r_parity   <= ^w_result;
         r_acc      <= w_result;
      end else if (w_deliver) begin
         r_s2_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (w_deliver && (r_count != c_cnt_max)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_s2_valid;
   assign bus.out       = r_out;
   assign bus.zero_flag = r_zero;
   assign bus.parity    = r_parity;
   assign bus.res_count = r_count;

endmodule

`default_nettype wire
